// File: rtl/stack_pkg.sv
// rtl/stack_pkg.sv - opcodes, control encodings, FSM states and per-opcode stack usage
package stack_pkg;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_PUSHI = 4'h1;
  localparam logic [3:0] OP_LOAD  = 4'h2;
  localparam logic [3:0] OP_STORE = 4'h3;
  localparam logic [3:0] OP_POPR  = 4'h4;
  localparam logic [3:0] OP_PUSHR = 4'h5;
  localparam logic [3:0] OP_ALU   = 4'h6;
  localparam logic [3:0] OP_JUMP  = 4'h7;
  localparam logic [3:0] OP_HALT  = 4'hF;

  localparam logic [1:0] SRC_ALU = 2'd0;
  localparam logic [1:0] SRC_IMM = 2'd1;
  localparam logic [1:0] SRC_MEM = 2'd2;
  localparam logic [1:0] SRC_REG = 2'd3;

  localparam logic [1:0] ES_PUSH = 2'd0;
  localparam logic [1:0] ES_POP  = 2'd1;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EX1,
    ST_EX2,
    ST_EX3,
    ST_HALT,
    ST_FAULT
  } state_t;

  typedef struct packed {
    logic [1:0] pops;
    logic [1:0] pushes;
  } stack_use_t;

  // Entries an instruction needs on the stack (pops) and the pushes that follow them.
  function automatic stack_use_t stack_use(input logic [3:0] op);
    stack_use_t u;
    u = '0;
    case (op)
      OP_PUSHI, OP_PUSHR: u.pushes = 2'd1;
      OP_LOAD: begin
        u.pops   = 2'd1;
        u.pushes = 2'd1;
      end
      OP_STORE: u.pops = 2'd2;
      OP_POPR:  u.pops = 2'd1;
      OP_ALU: begin
        u.pops   = 2'd2;
        u.pushes = 2'd1;
      end
      default: ;
    endcase
    return u;
  endfunction

endpackage

// File: rtl/stack_depth_ctr.sv
// rtl/stack_depth_ctr.sv - expression-stack depth counter with over/underflow pre-check
module stack_depth_ctr
  import stack_pkg::*;
#(
  parameter int STACK_DEPTH = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] pops,
  input  logic [1:0] pushes,
  input  logic       es_act,
  input  logic [1:0] es_op,
  input  logic       pop_num,
  output logic [4:0] depth,
  output logic       check_ok
);

  logic [6:0] depth_w;
  logic [6:0] after_pop;

  // Widened so the underflowed difference cannot alias a legal depth.
  assign depth_w   = {2'b00, depth};
  assign after_pop = depth_w - {5'b00000, pops};
  assign check_ok  = (depth_w >= {5'b00000, pops}) &&
                     ((after_pop + {5'b00000, pushes}) <= 7'(STACK_DEPTH));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      depth <= '0;
    end else if (es_act) begin
      if (es_op == ES_PUSH) depth <= depth + 5'd1;
      else                  depth <= depth - (pop_num ? 5'd2 : 5'd1);
    end
  end

endmodule

// File: rtl/stack_ctrl_fsm.sv
// rtl/stack_ctrl_fsm.sv - fetch/decode/execute sequencer for the stack processor datapath
module stack_ctrl_fsm
  import stack_pkg::*;
#(
  parameter int STACK_DEPTH = 16,
  parameter int PC_W        = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            run,
  input  logic [15:0]     instr,
  output logic [PC_W-1:0] pc,
  output logic [15:0]     push_in,
  output logic [1:0]      pushSrc,
  output logic            ESAct,
  output logic [1:0]      ESOp,
  output logic            popNum,
  output logic            wea,
  output logic            regWrite,
  output logic [1:0]      regAddress,
  output logic [2:0]      alu_op,
  output logic [4:0]      depth,
  output logic            halted,
  output logic            fault,
  output logic            illegal_op
);

  state_t     state, state_nxt;
  logic [15:0] ir;
  logic [3:0]  opcode;
  stack_use_t  use_dec;
  logic        check_ok;

  assign opcode  = ir[15:12];
  assign use_dec = stack_use(instr[15:12]);

  stack_depth_ctr #(.STACK_DEPTH(STACK_DEPTH)) u_depth (
    .clk      (clk),
    .reset    (reset),
    .pops     (use_dec.pops),
    .pushes   (use_dec.pushes),
    .es_act   (ESAct),
    .es_op    (ESOp),
    .pop_num  (popNum),
    .depth    (depth),
    .check_ok (check_ok)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_FETCH;
      pc    <= '0;
      ir    <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_DECODE) begin
        ir <= instr;
        pc <= (instr[15:12] == OP_JUMP) ? instr[PC_W-1:0] : pc + PC_W'(1);
      end
    end
  end

  // Depth is checked against the incoming word so a trap lands before any stack strobe.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_FETCH:  if (run) state_nxt = ST_DECODE;
      ST_DECODE: begin
        if (!check_ok)                     state_nxt = ST_FAULT;
        else if (instr[15:12] == OP_HALT)  state_nxt = ST_HALT;
        else if (instr[15:12] == OP_JUMP)  state_nxt = ST_FETCH;
        else                               state_nxt = ST_EX1;
      end
      ST_EX1:   state_nxt = (opcode == OP_LOAD || opcode == OP_ALU) ? ST_EX2 : ST_FETCH;
      ST_EX2:   state_nxt = (opcode == OP_LOAD) ? ST_EX3 : ST_FETCH;
      ST_EX3:   state_nxt = ST_FETCH;
      ST_HALT:  state_nxt = ST_HALT;
      ST_FAULT: state_nxt = ST_FAULT;
      default:  state_nxt = ST_FETCH;
    endcase
  end

  always_comb begin
    push_in    = '0;
    pushSrc    = SRC_ALU;
    ESAct      = 1'b0;
    ESOp       = ES_PUSH;
    popNum     = 1'b0;
    wea        = 1'b0;
    regWrite   = 1'b0;
    regAddress = '0;
    alu_op     = '0;
    illegal_op = 1'b0;
    case (state)
      ST_EX1: begin
        case (opcode)
          OP_NOP, OP_LOAD: ;
          OP_PUSHI: begin
            ESAct   = 1'b1;
            pushSrc = SRC_IMM;
            push_in = {{4{ir[11]}}, ir[11:0]};
          end
          OP_STORE: begin
            wea    = 1'b1;
            ESAct  = 1'b1;
            ESOp   = ES_POP;
            popNum = 1'b1;
          end
          OP_POPR: begin
            regWrite   = 1'b1;
            regAddress = ir[1:0];
            ESAct      = 1'b1;
            ESOp       = ES_POP;
          end
          OP_PUSHR: begin
            regAddress = ir[1:0];
            pushSrc    = SRC_REG;
            ESAct      = 1'b1;
          end
          OP_ALU: begin
            alu_op = ir[2:0];
            ESAct  = 1'b1;
            ESOp   = ES_POP;
            popNum = 1'b1;
          end
          default: illegal_op = 1'b1;
        endcase
      end
      ST_EX2: begin
        ESAct = 1'b1;
        if (opcode == OP_LOAD) begin
          ESOp    = ES_POP;
          pushSrc = SRC_MEM;
        end
      end
      ST_EX3: begin
        ESAct   = 1'b1;
        pushSrc = SRC_MEM;
      end
      default: ;
    endcase
  end

  assign halted = (state == ST_HALT);
  assign fault  = (state == ST_FAULT);

endmodule

// File: tb/tb_stack_ctrl_fsm.sv
// tb/tb_stack_ctrl_fsm.sv - scoreboard bench for stack_ctrl_fsm driven by a program-level reference model
module tb_stack_ctrl_fsm;

  localparam int STACK_DEPTH = 16;
  localparam int PC_W        = 8;

  logic            clk   = 1'b0;
  logic            reset = 1'b0;
  logic            run   = 1'b0;
  logic [15:0]     instr;
  logic [PC_W-1:0] pc;
  logic [15:0]     push_in;
  logic [1:0]      pushSrc;
  logic            ESAct;
  logic [1:0]      ESOp;
  logic            popNum;
  logic            wea;
  logic            regWrite;
  logic [1:0]      regAddress;
  logic [2:0]      alu_op;
  logic [4:0]      depth;
  logic            halted;
  logic            fault;
  logic            illegal_op;

  logic [15:0] imem [256];
  int          cyc = 0;
  int          errors = 0;
  int          checks = 0;
  logic [34:0] exp_ev[$];
  int          exp_pc_q[$];
  int          exp_gap_q[$];
  logic        exp_halt, exp_fault;
  int          exp_depth, exp_final_pc;

  stack_ctrl_fsm #(.STACK_DEPTH(STACK_DEPTH), .PC_W(PC_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
    .instr      (instr),
    .pc         (pc),
    .push_in    (push_in),
    .pushSrc    (pushSrc),
    .ESAct      (ESAct),
    .ESOp       (ESOp),
    .popNum     (popNum),
    .wea        (wea),
    .regWrite   (regWrite),
    .regAddress (regAddress),
    .alu_op     (alu_op),
    .depth      (depth),
    .halted     (halted),
    .fault      (fault),
    .illegal_op (illegal_op)
  );

  assign instr = imem[pc];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Event word: act, op, popNum, src, wea, regWrite, regAddr, alu, illegal, push_in, depth-before.
  function automatic logic [34:0] mk_ev(input int act, input int op, input int pn, input int src,
                                        input int we, input int rw, input int ra, input int alu,
                                        input int ill, input int pin, input int d);
    return {act[0], op[1:0], pn[0], src[1:0], we[0], rw[0], ra[1:0], alu[2:0], ill[0],
            pin[15:0], d[4:0]};
  endfunction

  task automatic run_model();
    int d, p, gap, pops, pushes, np;
    logic [15:0] w;
    logic [3:0]  op;
    logic [11:0] imm;
    int sx;
    d = 0; p = 0; gap = 2;
    exp_halt = 1'b0; exp_fault = 1'b0;
    for (int step = 0; step < 200; step++) begin
      w = imem[p]; op = w[15:12]; imm = w[11:0];
      sx = int'({{4{imm[11]}}, imm});
      pops = 0; pushes = 0;
      case (op)
        4'h1, 4'h5: pushes = 1;
        4'h2: begin pops = 1; pushes = 1; end
        4'h3: pops = 2;
        4'h4: pops = 1;
        4'h6: begin pops = 2; pushes = 1; end
        default: ;
      endcase
      np = (op == 4'h7) ? int'(imm[7:0]) : (p + 1) % 256;
      exp_pc_q.push_back(np);
      exp_gap_q.push_back(gap);
      p = np;
      if (d < pops || d - pops + pushes > STACK_DEPTH) begin exp_fault = 1'b1; break; end
      if (op == 4'hF) begin exp_halt = 1'b1; break; end
      case (op)
        4'h0: gap = 3;
        4'h1: begin exp_ev.push_back(mk_ev(1, 0, 0, 1, 0, 0, 0, 0, 0, sx, d)); gap = 3; end
        4'h2: begin
          exp_ev.push_back(mk_ev(1, 1, 0, 2, 0, 0, 0, 0, 0, 0, d));
          exp_ev.push_back(mk_ev(1, 0, 0, 2, 0, 0, 0, 0, 0, 0, d - 1));
          gap = 5;
        end
        4'h3: begin exp_ev.push_back(mk_ev(1, 1, 1, 0, 1, 0, 0, 0, 0, 0, d)); gap = 3; end
        4'h4: begin exp_ev.push_back(mk_ev(1, 1, 0, 0, 0, 1, int'(imm[1:0]), 0, 0, 0, d)); gap = 3; end
        4'h5: begin exp_ev.push_back(mk_ev(1, 0, 0, 3, 0, 0, int'(imm[1:0]), 0, 0, 0, d)); gap = 3; end
        4'h6: begin
          exp_ev.push_back(mk_ev(1, 1, 1, 0, 0, 0, 0, int'(imm[2:0]), 0, 0, d));
          exp_ev.push_back(mk_ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, d - 2));
          gap = 4;
        end
        4'h7: gap = 2;
        default: begin exp_ev.push_back(mk_ev(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, d)); gap = 3; end
      endcase
      d = d - pops + pushes;
    end
    exp_depth = d;
    exp_final_pc = p;
  endtask

  // Monitor: every cycle with any control active must match the next expected event.
  initial begin : monitor
    logic [34:0] cur, e;
    logic [7:0]  prev_pc;
    int          last_cyc, g, np;
    prev_pc = '0; last_cyc = 0;
    forever begin
      @(negedge clk);
      if (!reset || !run) begin
        // The next edge starts the first FETCH cycle.
        last_cyc = cyc + 1;
        prev_pc  = pc;
      end else begin
        cur = {ESAct, ESOp, popNum, pushSrc, wea, regWrite, regAddress, alu_op, illegal_op,
               push_in, depth};
        if (|cur[34:5]) begin
          if (exp_ev.size() == 0) begin
            checks++; errors++;
            $display("FAIL ev_unexpected: got 0x%0h expected no activity", cur);
          end else begin
            e = exp_ev.pop_front();
            chk("event", cur, e);
          end
        end
        if (pc != prev_pc) begin
          if (exp_pc_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL pc_unexpected: got 0x%0h expected no change from 0x%0h", pc, prev_pc);
          end else begin
            np = exp_pc_q.pop_front();
            g  = exp_gap_q.pop_front();
            chk("pc_next", pc, np);
            chk("instr_cycles", cyc - last_cyc, g);
          end
          prev_pc  = pc;
          last_cyc = cyc;
        end
      end
    end
  end

  task automatic begin_reset();
    @(posedge clk);
    #2 reset = 1'b0;
    exp_ev.delete();
    exp_pc_q.delete();
    exp_gap_q.delete();
    for (int a = 0; a < 256; a++) imem[a] = 16'hF000;
  endtask

  task automatic end_reset();
    run_model();
    @(posedge clk);
    #2 reset = 1'b1;
  endtask

  task automatic finish_prog(input string name);
    int budget;
    budget = 3000;
    while ((exp_ev.size() != 0 || exp_pc_q.size() != 0) && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    chk({name, "_timeout"}, (budget == 0), 0);
    repeat (8) @(negedge clk);
    chk({name, "_halted"}, halted, exp_halt);
    chk({name, "_fault"}, fault, exp_fault);
    chk({name, "_depth"}, depth, exp_depth);
    chk({name, "_pc"}, pc, exp_final_pc);
  endtask

  task automatic gen_random();
    int r, t;
    logic [3:0] hi;
    logic [11:0] imm;
    for (int a = 0; a < 24; a++) begin
      r   = $urandom_range(0, 99);
      imm = 12'($urandom);
      if (r < 35)      imem[a] = {4'h1, imm};
      else if (r < 45) imem[a] = {4'h2, imm};
      else if (r < 55) imem[a] = {4'h3, imm};
      else if (r < 62) imem[a] = {4'h4, imm};
      else if (r < 70) imem[a] = {4'h5, imm};
      else if (r < 82) imem[a] = {4'h6, imm};
      else if (r < 87) imem[a] = {4'h0, imm};
      else if (r < 92) begin
        hi = 4'($urandom_range(8, 14));
        imem[a] = {hi, imm};
      end else begin
        t  = a + $urandom_range(2, 4);
        hi = 4'($urandom);
        imem[a] = {4'h7, hi, t[7:0]};
      end
    end
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic seen;

    // run held low: FSM must stay in FETCH with pc 0.
    begin_reset();
    imem[0] = 16'h1005;
    end_reset();
    repeat (4) @(negedge clk);
    chk("run_low_pc", pc, 0);
    chk("run_low_idle", {ESAct, wea, regWrite, halted, fault, depth}, 0);
    @(posedge clk);
    #2 run = 1'b1;
    finish_prog("pushi5");

    begin_reset();
    imem[0] = 16'h1007; imem[1] = 16'h1003; imem[2] = 16'h6000;
    end_reset();
    finish_prog("alu");

    begin_reset();
    imem[0] = 16'h100F; imem[1] = 16'h1000; imem[2] = 16'h3000;
    end_reset();
    finish_prog("store");

    begin_reset();
    imem[0] = 16'h4002;
    end_reset();
    finish_prog("popr_underflow");

    begin_reset();
    for (int a = 0; a < 17; a++) imem[a] = 16'h1800 | 16'(a);
    end_reset();
    finish_prog("overflow");

    begin_reset();
    imem[0] = 16'h7020; imem[8'h20] = 16'hA123;
    end_reset();
    finish_prog("jump_illegal");

    begin_reset();
    imem[0] = 16'h5003; imem[1] = 16'h2000; imem[2] = 16'h4001; imem[3] = 16'h1ABC;
    imem[4] = 16'h5002; imem[5] = 16'h6005; imem[6] = 16'hE000;
    end_reset();
    finish_prog("mixed");

    // Reset asserted during EX2 of LOAD aborts at once.
    begin_reset();
    imem[0] = 16'h1009; imem[1] = 16'h2000;
    end_reset();
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (ESAct && ESOp == 2'd1 && pushSrc == 2'd2) seen = 1'b1;
    end
    chk("abort_reached_ex2", seen, 1);
    #1 reset = 1'b0;
    #1 chk("abort_outputs_zero", {pc, push_in, pushSrc, ESAct, ESOp, popNum, wea, regWrite,
                                  regAddress, alu_op, depth, halted, fault, illegal_op}, 0);
    begin_reset();
    imem[0] = 16'h1FFF;
    end_reset();
    @(negedge clk);
    chk("restart_pc", pc, 0);
    finish_prog("after_abort");

    for (int k = 0; k < 8; k++) begin
      begin_reset();
      gen_random();
      end_reset();
      finish_prog("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stack_ctrl_fsm.md
Name: stack_ctrl_fsm

Overview:
Multi-cycle control unit of the stack processor, directly upstream of the memory/register-file/expression-stack datapath. It fetches 16-bit instructions, decodes them, and sequences the datapath controls (ESAct, ESOp, popNum, pushSrc, wea, regWrite, regAddress, push_in). It also tracks expression-stack depth and traps on overflow or underflow before the stack is corrupted.

Parameters:
STACK_DEPTH, 16, number of expression-stack entries; valid depth range is 0..STACK_DEPTH.
PC_W, 8, program-counter width.

Ports:
clk  in  1  system clock; all state changes on the rising edge.
reset  in  1  asynchronous, active-low reset.
run  in  1  when low, FSM holds in FETCH and issues no fetch.
instr  in  16  instruction-memory read data; valid the cycle after pc is presented.
pc  out  PC_W  instruction address.
push_in  out  16  sign-extended imm12 for PUSHI.
pushSrc  out  2  push source: 0 = ALU result, 1 = push_in, 2 = mem_out, 3 = register file.
ESAct  out  1  expression-stack action enable.
ESOp  out  2  stack operation: 0 = push, 1 = pop.
popNum  out  1  pop count: 0 = one entry, 1 = two entries.
wea  out  1  data-memory write enable (mem[a_out] = b_out).
regWrite  out  1  register-file write enable (reg = a_out).
regAddress  out  2  register-file index, taken from imm[1:0].
alu_op  out  3  ALU function, taken from imm[2:0].
depth  out  5  current stack depth.
halted  out  1  sticky; set by HALT.
fault  out  1  sticky; set by stack overflow or underflow.
illegal_op  out  1  one-cycle pulse on an undefined opcode.

Behaviour:
- Reset (asynchronous, reset=0): state=FETCH, pc=0, depth=0, ir=0, all control outputs 0, halted=0, fault=0. Outputs are Moore, decoded from state and ir.
- States: FETCH, DECODE, EX1, EX2, EX3, HALT, FAULT.
- FETCH: present pc. If run=1, go to DECODE; otherwise stay.
- DECODE: ir <= instr; pc <= pc+1 (wraps at 2^PC_W); all controls 0. Check depth against instr's pop count P and net push N:
  - depth < P -> FAULT (underflow).
  - depth - P + pushes > STACK_DEPTH -> FAULT (overflow).
  - Otherwise go to EX1; HALT and JUMP branch directly.
- Opcode ir[15:12]; imm = ir[11:0]. Cycle counts include FETCH and DECODE.
  - 0 NOP: EX1 idle -> FETCH. 3 cycles.
  - 1 PUSHI: EX1 ESAct=1, ESOp=0, pushSrc=1, push_in=sext(imm); depth+1. 3 cycles.
  - 2 LOAD (P=1, N=0): EX1 idle, memory reads at a_out; EX2 pop one (popNum=0, pushSrc=2); EX3 push with pushSrc=2. 5 cycles.
  - 3 STORE (P=2): EX1 wea=1, ESAct=1, ESOp=1, popNum=1; depth-2. 3 cycles.
  - 4 POPR (P=1): EX1 regWrite=1, regAddress=imm[1:0], pop one; depth-1.
  - 5 PUSHR: EX1 regAddress=imm[1:0], pushSrc=3, push; depth+1.
  - 6 ALU (P=2, N=-1): EX1 alu_op valid, pop two (ALU result registered in datapath); EX2 push with pushSrc=0. Net depth-1. 4 cycles.
  - 7 JUMP: DECODE loads pc <= imm[PC_W-1:0], overriding pc+1 -> FETCH.
  - F HALT: -> HALT; halted=1; stays until reset.
  - Other opcodes: illegal_op=1 for one cycle in EX1, executed as NOP.
- FAULT: fault=1 and all controls held at 0 until reset. Neither the stack nor memory is touched.
- depth updates on the same edge as the corresponding ESAct cycle. wea and regWrite are never asserted in the same cycle.
- Reset mid-instruction aborts immediately; the partial operation is not completed.
- run is sampled only in FETCH; dropping it mid-instruction does not stall execution.

Decomposition:
- Package stack_pkg: opcode localparams, pushSrc/ESOp encodings, state encoding, and the P/N lookup function.
- One sub-module, stack_depth_ctr: depth counter with check_ok output; inputs are P, N and the ESAct/ESOp/popNum strobes.

Test Plan:
- Reset then PUSHI 5 -> EX1 shows push_in=0x0005, pushSrc=1, ESAct=1, ESOp=0; depth=1; pc=1 after 3 cycles.
- PUSHI 7, PUSHI 3, ALU alu_op=0 -> EX1 pop two (popNum=1), EX2 push pushSrc=0; depth 2->1; 4-cycle instruction.
- PUSHI 15, PUSHI 0, STORE -> one cycle with wea=1 and popNum=1; depth=0.
- Reset then POPR r2 at depth 0 -> FAULT, fault=1, ESAct never asserted. 17 PUSHI with STACK_DEPTH=16 -> 17th faults, depth stays 16.
- JUMP 0x20 -> pc=0x20 at the next FETCH. Opcode 0xA -> illegal_op high exactly 1 cycle. HALT -> halted=1, pc frozen.
- Reset driven low during EX2 of LOAD -> all outputs 0 immediately; after release, fetch restarts at pc=0.
